// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle control sequencer.
//
// Sequences one shared ALU, one shared instruction/data memory port and the
// register file through FETCH/DECODE/EXEC/MEM/WB. The memory port is handled
// with a ready handshake: a request is held without gaps until mem_ready.
// Retired instructions are counted in instr_cnt.
//
// Build option:
//   MC_CTRL_TRAP_EN  when defined, an unsupported instruction sends the FSM to
//                    TRAP, which holds until rst and reports illegal=1. When
//                    undefined, unsupported instructions retire as a NOP and
//                    illegal is tied to 0.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   Op, Funct       IR[31:26], IR[5:0]; held stable by the IR after IRWrite
//   Zero            ALU zero flag, meaningful in EXEC
//   mem_ready       memory completes the current read/write this cycle
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   enables
//   IorD            memory address select: 0=PC, 1=ALUOut
//   EXTOp           1=sign extend immediate
//   ALUSrcA         0=PC, 1=rs
//   ALUSrcB         00=rt, 01=4, 10=ext imm, 11=ext imm<<2
//   ALUOp           ALU function code
//   NPCOp           00=PC+4, 01=ALUOut, 10=jump, 11=rs
//   GPRSel          00=rd, 01=rt, 10=$31
//   WDSel           00=ALUOut, 01=MDR, 10=PC
//   state           current FSM state (debug)
//   instr_cnt       retired instruction count, wraps silently
//   illegal         sticky unsupported-instruction flag
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             EXTOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

`ifdef MC_CTRL_TRAP_EN
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4
  } state_t;
`endif

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;

  // Instruction decode from the IR fields.
  logic       w_rtype, w_addi, w_ori, w_lui, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
  logic       w_jr, w_jalr, w_r_alu, w_legal, w_take;
  logic [3:0] w_r_aluop;

  assign w_rtype = (Op == 6'b000000);
  assign w_addi  = (Op == 6'b001000);
  assign w_ori   = (Op == 6'b001101);
  assign w_lui   = (Op == 6'b001111);
  assign w_lw    = (Op == 6'b100011);
  assign w_sw    = (Op == 6'b101011);
  assign w_beq   = (Op == 6'b000100);
  assign w_bne   = (Op == 6'b000101);
  assign w_j     = (Op == 6'b000010);
  assign w_jal   = (Op == 6'b000011);
  assign w_jr    = w_rtype && (Funct == 6'b001000);
  assign w_jalr  = w_rtype && (Funct == 6'b001001);

  // R-type ALU function; w_r_alu marks a supported ALU funct.
  always_comb begin
    w_r_aluop = ALU_ADD;
    w_r_alu   = 1'b1;
    case (Funct)
      6'b100000: w_r_aluop = ALU_ADD;
      6'b100010: w_r_aluop = ALU_SUB;
      6'b100100: w_r_aluop = ALU_AND;
      6'b100101: w_r_aluop = ALU_OR;
      6'b101010: w_r_aluop = ALU_SLT;
      6'b000000: w_r_aluop = ALU_SLL;
      6'b000010: w_r_aluop = ALU_SRL;
      default:   w_r_alu   = 1'b0;
    endcase
  end

  assign w_legal = (w_rtype && (w_r_alu || w_jr || w_jalr)) || w_addi || w_ori ||
                   w_lui || w_lw || w_sw || w_beq || w_bne || w_j || w_jal;
  assign w_take  = (w_beq && Zero) || (w_bne && !Zero);

  // Next state and all control outputs are combinational from the state.
  always_comb begin
    w_state_next = r_state;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 4'b0000;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    case (r_state)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        EXTOp   = 1'b1;
        if (w_j || w_jal) begin
          PCWrite      = 1'b1;
          NPCOp        = 2'b10;
          w_state_next = S_FETCH;
          if (w_jal) begin
            RegWrite = 1'b1;
            GPRSel   = 2'b10;
            WDSel    = 2'b10;
          end
        end else if (w_jr || w_jalr) begin
          PCWrite      = 1'b1;
          NPCOp        = 2'b11;
          w_state_next = S_FETCH;
          if (w_jalr) begin
            RegWrite = 1'b1;
            WDSel    = 2'b10;
          end
        end else if (!w_legal) begin
`ifdef MC_CTRL_TRAP_EN
          w_state_next = S_TRAP;
`else
          w_state_next = S_FETCH;
`endif
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (w_rtype) begin
          ALUOp        = w_r_aluop;
          w_state_next = S_WB;
        end else if (w_addi || w_ori || w_lui) begin
          ALUSrcB      = 2'b10;
          EXTOp        = !w_ori;
          ALUOp        = w_addi ? ALU_ADD : (w_ori ? ALU_OR : ALU_LUI);
          w_state_next = S_WB;
        end else if (w_lw || w_sw) begin
          ALUSrcB      = 2'b10;
          EXTOp        = 1'b1;
          ALUOp        = ALU_ADD;
          w_state_next = S_MEM;
        end else begin
          // Only beq/bne reach here: compare rs-rt, redirect PC on taken.
          ALUOp        = ALU_SUB;
          w_state_next = S_FETCH;
          if (w_take) begin
            PCWrite = 1'b1;
            NPCOp   = 2'b01;
          end
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = w_lw;
        MemWrite = w_sw;
        if (mem_ready) w_state_next = w_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWrite     = 1'b1;
        WDSel        = w_lw ? 2'b01 : 2'b00;
        GPRSel       = w_rtype ? 2'b00 : 2'b01;
        w_state_next = S_FETCH;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: w_state_next = S_TRAP;
`endif
      default: w_state_next = S_FETCH;
    endcase
    // Reset kills every output immediately, including a pending request.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 4'b0000;
      NPCOp    = 2'b00;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      // A return to FETCH from anywhere else retires one instruction.
      if (r_state != S_FETCH && w_state_next == S_FETCH) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign state     = r_state;
  assign instr_cnt = r_cnt;

`ifdef MC_CTRL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- scoreboard bench for mc_ctrl.
// Each cycle the expected state/control vector is pushed when the inputs are
// driven and popped and compared at the following falling edge. A narrow
// counter width is used so the instr_cnt wrap is reached.
module tb_mc_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    Op = '0;
  logic [5:0]    Funct = '0;
  logic          Zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrcA;
  logic [1:0]    ALUSrcB, NPCOp, GPRSel, WDSel;
  logic [3:0]    ALUOp;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;
  logic          illegal;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
    .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
  );

  typedef enum int {K_R, K_ADDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                    K_J, K_JAL, K_JR, K_JALR, K_BAD} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      k;
    logic [3:0] alu;
  } ins_t;

  // Expected values per cycle; c_* selects which non-enable fields matter.
  typedef struct {
    logic [2:0]    st;
    logic          pcw, irw, mrd, mwr, rw;
    logic          iord, ext, srca;
    logic [1:0]    srcb;
    logic [3:0]    aluop;
    logic [1:0]    npc, gpr, wd;
    logic          c_iord, c_ext, c_srca, c_srcb, c_aluop, c_npc, c_gpr, c_wd;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_ill = 1'b0;
  ins_t          tbl[18];

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input kind_t k, input logic [3:0] alu);
    ins_t t;
    t.op = op; t.fn = fn; t.k = k; t.alu = alu;
    return t;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '{default: '0};
    e.st  = st;
    e.cnt = exp_cnt;
    e.ill = exp_ill;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    else
      n_pass++;
  endtask

  task automatic compare(input exp_t x);
    check_val("state", 32'(state), 32'(x.st));
    check_val("enables", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite}),
              32'({x.pcw, x.irw, x.mrd, x.mwr, x.rw}));
    if (x.c_iord)  check_val("IorD", 32'(IorD), 32'(x.iord));
    if (x.c_ext)   check_val("EXTOp", 32'(EXTOp), 32'(x.ext));
    if (x.c_srca)  check_val("ALUSrcA", 32'(ALUSrcA), 32'(x.srca));
    if (x.c_srcb)  check_val("ALUSrcB", 32'(ALUSrcB), 32'(x.srcb));
    if (x.c_aluop) check_val("ALUOp", 32'(ALUOp), 32'(x.aluop));
    if (x.c_npc)   check_val("NPCOp", 32'(NPCOp), 32'(x.npc));
    if (x.c_gpr)   check_val("GPRSel", 32'(GPRSel), 32'(x.gpr));
    if (x.c_wd)    check_val("WDSel", 32'(WDSel), 32'(x.wd));
    check_val("illegal", 32'(illegal), 32'(x.ill));
    check_val("instr_cnt", 32'(instr_cnt), 32'(x.cnt));
  endtask

  // One clock cycle: drive, push expectation, pop and compare at negedge.
  task automatic step(input logic mr, input logic z, input exp_t e);
    exp_t x;
    mem_ready = mr;
    Zero      = z;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    compare(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_enables", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
    check_val("rst_other", 32'({IorD, EXTOp, ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel}), 32'd0);
    check_val("rst_cnt", 32'(instr_cnt), 32'd0);
    check_val("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset done");
  endtask

  task automatic run_instr(input ins_t in, input int fs, input int ms, input logic z,
                           input logic abort_in_mem);
    exp_t e;
    logic taken;
    Op    = in.op;
    Funct = (in.op == 6'b000000) ? in.fn : 6'($urandom);
    // FETCH, with fs stalled cycles first.
    for (int i = 0; i <= fs; i++) begin
      e = blank(3'd0);
      e.mrd = 1'b1;
      e.c_iord = 1'b1; e.iord = 1'b0;
      e.c_srca = 1'b1; e.srca = 1'b0;
      e.c_srcb = 1'b1; e.srcb = 2'b01;
      e.c_aluop = 1'b1; e.aluop = 4'b0001;
      if (i == fs) begin
        e.pcw = 1'b1; e.irw = 1'b1;
        e.c_npc = 1'b1; e.npc = 2'b00;
      end
      step(i == fs, z, e);
    end
    // DECODE
    e = blank(3'd1);
    e.c_srca = 1'b1; e.srca = 1'b0;
    e.c_srcb = 1'b1; e.srcb = 2'b11;
    e.c_aluop = 1'b1; e.aluop = 4'b0001;
    e.c_ext = 1'b1; e.ext = 1'b1;
    case (in.k)
      K_J:    begin e.pcw = 1'b1; e.c_npc = 1'b1; e.npc = 2'b10; end
      K_JAL:  begin e.pcw = 1'b1; e.c_npc = 1'b1; e.npc = 2'b10; e.rw = 1'b1;
                    e.c_gpr = 1'b1; e.gpr = 2'b10; e.c_wd = 1'b1; e.wd = 2'b10; end
      K_JR:   begin e.pcw = 1'b1; e.c_npc = 1'b1; e.npc = 2'b11; end
      K_JALR: begin e.pcw = 1'b1; e.c_npc = 1'b1; e.npc = 2'b11; e.rw = 1'b1;
                    e.c_gpr = 1'b1; e.gpr = 2'b00; e.c_wd = 1'b1; e.wd = 2'b10; end
      default: ;
    endcase
    step(1'($urandom), z, e);
    if (in.k == K_J || in.k == K_JAL || in.k == K_JR || in.k == K_JALR) begin
      exp_cnt++;
      $display("instr op=%b fn=%b jump retired, cnt=%0d", in.op, Funct, exp_cnt);
      return;
    end
    if (in.k == K_BAD) begin
`ifdef MC_CTRL_TRAP_EN
      exp_ill = 1'b1;
      repeat (3) step(1'($urandom), 1'($urandom), blank(3'd5));
      $display("instr op=%b fn=%b trapped", in.op, Funct);
      do_reset();
`else
      exp_cnt++;
      $display("instr op=%b fn=%b retired as nop, cnt=%0d", in.op, Funct, exp_cnt);
`endif
      return;
    end
    // EXEC
    e = blank(3'd2);
    taken = (in.k == K_BEQ && z) || (in.k == K_BNE && !z);
    case (in.k)
      K_R: begin
        e.c_srca = 1'b1; e.srca = 1'b1; e.c_srcb = 1'b1; e.srcb = 2'b00;
        e.c_aluop = 1'b1; e.aluop = in.alu;
      end
      K_ADDI, K_ORI, K_LUI: begin
        e.c_srcb = 1'b1; e.srcb = 2'b10; e.c_ext = 1'b1; e.ext = (in.k != K_ORI);
        e.c_aluop = 1'b1; e.aluop = in.alu;
      end
      K_LW, K_SW: begin
        e.c_srcb = 1'b1; e.srcb = 2'b10; e.c_ext = 1'b1; e.ext = 1'b1;
        e.c_aluop = 1'b1; e.aluop = 4'b0001;
      end
      default: begin
        e.c_srcb = 1'b1; e.srcb = 2'b00; e.c_aluop = 1'b1; e.aluop = 4'b0010;
        e.pcw = taken;
        if (taken) begin e.c_npc = 1'b1; e.npc = 2'b01; end
      end
    endcase
    step(1'($urandom), z, e);
    if (in.k == K_BEQ || in.k == K_BNE) begin
      exp_cnt++;
      $display("instr op=%b zero=%b branch taken=%b, cnt=%0d", in.op, z, taken, exp_cnt);
      return;
    end
    // MEM, with ms stalled cycles first.
    if (in.k == K_LW || in.k == K_SW) begin
      for (int i = 0; i <= ms; i++) begin
        if (abort_in_mem && i == 2) begin
          check_val("mw_before_rst", 32'(MemWrite), 32'(in.k == K_SW));
          $display("instr op=%b aborted in MEM by reset", in.op);
          do_reset();
          return;
        end
        e = blank(3'd3);
        e.c_iord = 1'b1; e.iord = 1'b1;
        e.mrd = (in.k == K_LW);
        e.mwr = (in.k == K_SW);
        step(i == ms, z, e);
      end
      if (in.k == K_SW) begin
        exp_cnt++;
        $display("instr op=%b sw retired, cnt=%0d", in.op, exp_cnt);
        return;
      end
    end
    // WB
    e = blank(3'd4);
    e.rw = 1'b1;
    e.c_wd = 1'b1; e.wd = (in.k == K_LW) ? 2'b01 : 2'b00;
    e.c_gpr = 1'b1; e.gpr = (in.k == K_R) ? 2'b00 : 2'b01;
    step(1'($urandom), z, e);
    exp_cnt++;
    $display("instr op=%b fn=%b retired, cnt=%0d", in.op, Funct, exp_cnt);
  endtask

  initial begin
    ins_t bad_op, bad_fn;
    tbl[0]  = mk(6'b000000, 6'b100000, K_R, 4'b0001);
    tbl[1]  = mk(6'b000000, 6'b100010, K_R, 4'b0010);
    tbl[2]  = mk(6'b000000, 6'b100100, K_R, 4'b0011);
    tbl[3]  = mk(6'b000000, 6'b100101, K_R, 4'b0100);
    tbl[4]  = mk(6'b000000, 6'b101010, K_R, 4'b0101);
    tbl[5]  = mk(6'b000000, 6'b000000, K_R, 4'b1000);
    tbl[6]  = mk(6'b000000, 6'b000010, K_R, 4'b1001);
    tbl[7]  = mk(6'b000000, 6'b001000, K_JR, 4'b0000);
    tbl[8]  = mk(6'b000000, 6'b001001, K_JALR, 4'b0000);
    tbl[9]  = mk(6'b001000, 6'b000000, K_ADDI, 4'b0001);
    tbl[10] = mk(6'b001101, 6'b000000, K_ORI, 4'b0100);
    tbl[11] = mk(6'b001111, 6'b000000, K_LUI, 4'b1010);
    tbl[12] = mk(6'b100011, 6'b000000, K_LW, 4'b0001);
    tbl[13] = mk(6'b101011, 6'b000000, K_SW, 4'b0001);
    tbl[14] = mk(6'b000100, 6'b000000, K_BEQ, 4'b0010);
    tbl[15] = mk(6'b000101, 6'b000000, K_BNE, 4'b0010);
    tbl[16] = mk(6'b000010, 6'b000000, K_J, 4'b0000);
    tbl[17] = mk(6'b000011, 6'b000000, K_JAL, 4'b0000);
    bad_op = mk(6'b111111, 6'b000000, K_BAD, 4'b0000);
    bad_fn = mk(6'b000000, 6'b111111, K_BAD, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed cases first.
    run_instr(tbl[9], 0, 0, 1'b0, 1'b0);    // addi
    run_instr(tbl[12], 0, 3, 1'b0, 1'b0);   // lw, MEM stalled 3 cycles
    run_instr(tbl[14], 0, 0, 1'b1, 1'b0);   // beq taken
    run_instr(tbl[14], 0, 0, 1'b0, 1'b0);   // beq not taken
    run_instr(tbl[15], 0, 0, 1'b0, 1'b0);   // bne taken
    run_instr(tbl[15], 0, 0, 1'b1, 1'b0);   // bne not taken
    run_instr(tbl[17], 0, 0, 1'b0, 1'b0);   // jal

    // Every instruction twice with random stalls and Zero; counter wraps.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 18; i++)
        run_instr(tbl[i], int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                  1'($urandom), 1'b0);

    run_instr(bad_op, 0, 0, 1'b0, 1'b0);
    run_instr(bad_fn, 1, 0, 1'b0, 1'b0);

    // sw stalled in MEM, then reset mid-request.
    run_instr(tbl[9], 0, 0, 1'b0, 1'b0);
    run_instr(tbl[13], 0, 5, 1'b0, 1'b1);
    run_instr(tbl[9], 0, 0, 1'b0, 1'b0);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
